gate_sweep_checker: RTL and testbench
=====================================

# gate_sweep_checker

Parametrised hardware self-check engine for N-input logic gates. On a start pulse it drives every input vector 0 to 2^N-1 onto a gate-under-test, waits a programmable settle time, and compares the gate's response against a selectable reference function. It reports error count, first failing vector and pass/fail. It sits beside the gate primitives (and2 and successors) as an on-FPGA replacement for exhaustive-sweep benches.

## Interface
- N, default 2: gate input width, legal range 1..8.
- SETTLE, default 2: cycles each vector is held before sampling, legal range ≥1.
- ERR_W, default N+1: error counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin sweep; level sampled only in IDLE.
- mode  in  3  reference function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 const-0, 7 const-1. Latched at start.
- dut_out  in  1  response of the gate-under-test.
- dut_in  out  N  stimulus vector to the gate-under-test.
- busy  out  1  sweep in progress (SETTLE, CHECK, DONE).
- done  out  1  one-cycle completion pulse.
- pass  out  1  1 when last sweep had zero mismatches; held until next start.
- err_count  out  ERR_W  mismatch count, saturating at 2^ERR_W-1.
- first_fail_vec  out  N  vector of first mismatch in the current sweep.
- fail_valid  out  1  first_fail_vec holds a captured vector.

## Operation
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE: when start=1 at an edge, the following happen on that edge:
  - latch mode;
  - dut_in←0, err_count←0, fail_valid←0, first_fail_vec←0, pass←0;
  - load settle counter with SETTLE-1;
  - go to SETTLE.
- SETTLE: counter decrements each cycle. At zero, go to CHECK.
- CHECK: compare dut_out with ref(dut_in, latched mode).
  - On mismatch: err_count increments, saturating. If fail_valid=0, capture first_fail_vec←dut_in and set fail_valid←1.
  - If dut_in is all-ones, go to DONE and set pass←(no mismatch this sweep, including this cycle).
  - Otherwise dut_in increments, the counter reloads, and the FSM goes to SETTLE.
  - Last-vector detection is explicit, so dut_in never wraps.
- DONE: done=1 for exactly one cycle, then go to IDLE. dut_in holds all-ones until the next start.
- start while busy (including DONE) is ignored. If start is held high, a new sweep begins from IDLE on the edge after DONE.
- mode changes during a sweep are ignored.
- Reference functions reduce over all N bits (AND = &dut_in, etc.). Modes 6/7 are stuck-at references.

## Timing
- Reset (async, any state): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, fail_valid=0, all immediately.
- Release is synchronous to clk; the first sampling edge follows release.
- Each vector occupies SETTLE+1 cycles. dut_out is sampled in the last of these (CHECK), SETTLE cycles after dut_in changed.
- done asserts on edge 2^N·(SETTLE+1) after the start-sampling edge. pass, err_count and first_fail_vec are final on that same edge.
- With start held high, sweep period is 2^N·(SETTLE+1)+2 cycles.
- All outputs are registered. No combinational path from dut_out to any output.

## Structure
- Shared include/package gate_sweep_pkg holds:
  - mode encodings MODE_AND..MODE_ONE;
  - FSM state encodings.
- One combinational sub-module, gate_ref_model (params N; ports vec, mode → exp), computes the reference output. It is reusable by future gate benches.
- gate_sweep_checker holds the FSM, settle counter, vector counter and result registers.

## Test plan
- N=2, SETTLE=2, mode=AND, dut_out=&dut_in → done on edge 12 after start, pass=1, err_count=0, fail_valid=0.
- N=2, mode=OR, dut_out=&dut_in → err_count=2, first_fail_vec=2'b01, fail_valid=1, pass=0.
- N=2, mode=NAND, dut_out tied 0 → err_count=3, first_fail_vec=2'b00, pass=0.
- N=3, SETTLE=2, ERR_W=2, mode=XOR, dut_out=~^dut_in → err_count saturates at 3, first_fail_vec=3'b000, done on edge 24.
- rst_n low during vector 2 of a sweep → all outputs 0 immediately. A new start then completes a clean AND sweep with pass=1.
- start held high for 40 cycles, N=2, SETTLE=2 → done pulses exactly every 14 cycles. mode toggled mid-sweep has no effect on that sweep's results.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep checker: reference-function modes and FSM states.
package gate_sweep_pkg;

   localparam int unsigned MODE_W = 3;
   localparam logic [MODE_W-1:0] MODE_AND  = 3'd0;
   localparam logic [MODE_W-1:0] MODE_OR   = 3'd1;
   localparam logic [MODE_W-1:0] MODE_XOR  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_NAND = 3'd3;
   localparam logic [MODE_W-1:0] MODE_NOR  = 3'd4;
   localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;
   localparam logic [MODE_W-1:0] MODE_ZERO = 3'd6;
   localparam logic [MODE_W-1:0] MODE_ONE  = 3'd7;

   localparam int unsigned ST_W = 2;
   localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
   localparam logic [ST_W-1:0] ST_SETTLE = 2'd1;
   localparam logic [ST_W-1:0] ST_CHECK  = 2'd2;
   localparam logic [ST_W-1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for an N-input gate: reduces vec according to mode.
module gate_ref_model
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0]      vec,
   input  logic [MODE_W-1:0] mode,
   output logic              exp
);

   always_comb begin
      exp = 1'b0;
      case (mode)
         MODE_AND:  exp = &vec;
         MODE_OR:   exp = |vec;
         MODE_XOR:  exp = ^vec;
         MODE_NAND: exp = ~&vec;
         MODE_NOR:  exp = ~|vec;
         MODE_XNOR: exp = ~^vec;
         MODE_ZERO: exp = 1'b0;
         MODE_ONE:  exp = 1'b1;
         default:   exp = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive self-check engine: sweeps every N-bit vector onto a gate, waits SETTLE
// cycles, compares against a reference and reports error count, first failure and pass.
module gate_sweep_checker
   import gate_sweep_pkg::*;
#(
   parameter int unsigned N      = 2,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned ERR_W  = N + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [MODE_W-1:0] mode,
   input  logic              dut_out,
   output logic [N-1:0]      dut_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [N-1:0]      first_fail_vec,
   output logic              fail_valid
);

   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [N-1:0]     VEC_ONES = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   logic [ST_W-1:0]   state_q, state_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N-1:0]      dut_in_q, dut_in_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [N-1:0]      ffv_q, ffv_d;
   logic              fv_q, fv_d;

   logic              exp_c;
   logic              mismatch_c;

   gate_ref_model #(.N(N)) u_ref (
      .vec  (dut_in_q),
      .mode (mode_q),
      .exp  (exp_c)
   );

   assign mismatch_c = (dut_out != exp_c);

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_AND;
         cnt_q    <= '0;
         dut_in_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         ffv_q    <= '0;
         fv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         cnt_q    <= cnt_d;
         dut_in_q <= dut_in_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         err_q    <= err_d;
         ffv_q    <= ffv_d;
         fv_q     <= fv_d;
      end
   end

   // Next-state and result update
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      dut_in_d = dut_in_q;
      done_d   = 1'b0;
      pass_d   = pass_q;
      err_d    = err_q;
      ffv_d    = ffv_q;
      fv_d     = fv_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d   = mode;
               dut_in_d = '0;
               err_d    = '0;
               fv_d     = 1'b0;
               ffv_d    = '0;
               pass_d   = 1'b0;
               cnt_d    = CNT_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_CHECK: begin
            if (mismatch_c) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + ERR_W'(1);
               end
               if (!fv_q) begin
                  ffv_d = dut_in_q;
                  fv_d  = 1'b1;
               end
            end
            // Explicit last-vector test keeps dut_in parked at all-ones
            if (dut_in_q == VEC_ONES) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               pass_d  = !fv_q && !mismatch_c;
            end else begin
               dut_in_d = dut_in_q + N'(1);
               cnt_d    = CNT_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign dut_in         = dut_in_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_fail_vec = ffv_q;
   assign fail_valid     = fv_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: two instances (N=2 and N=3/ERR_W=2) with
// directed sweeps; expected results are queued at start and checked when done pulses.
module tb_gate_sweep_checker;
   import gate_sweep_pkg::*;

   typedef struct {
      int err;
      int ffv;
      int fv;
      int pass;
      int done_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_miss = 0;

   exp_t q2[$];
   exp_t q3[$];

   // N=2 instance
   logic        start2 = 1'b0;
   logic [2:0]  mode2 = MODE_AND;
   int          fn2 = 0;
   logic        out2;
   logic [1:0]  in2;
   logic        busy2, done2, pass2, fv2;
   logic [2:0]  err2;
   logic [1:0]  ffv2;

   // N=3, ERR_W=2 instance
   logic        start3 = 1'b0;
   logic [2:0]  mode3 = MODE_XOR;
   int          fn3 = 4;
   logic        out3;
   logic [2:0]  in3;
   logic        busy3, done3, pass3, fv3;
   logic [1:0]  err3;
   logic [2:0]  ffv3;

   gate_sweep_checker #(.N(2), .SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .dut_out(out2),
      .dut_in(in2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .first_fail_vec(ffv2), .fail_valid(fv2)
   );

   gate_sweep_checker #(.N(3), .SETTLE(2), .ERR_W(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .dut_out(out3),
      .dut_in(in3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .first_fail_vec(ffv3), .fail_valid(fv3)
   );

   // Emulated gate-under-test: 0 AND, 1 tied-0, 2 tied-1, 3 XOR, 4 XNOR
   function automatic logic gate_fn(input int fn, input logic [7:0] v);
      case (fn)
         0: return &v;
         1: return 1'b0;
         2: return 1'b1;
         3: return ^v;
         default: return ~^v;
      endcase
   endfunction

   always_comb out2 = gate_fn(fn2, {6'h3f, in2});
   always_comb out3 = (fn3 == 0) ? gate_fn(fn3, {5'h1f, in3}) : gate_fn(fn3, {5'h00, in3});

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop an expectation on every done pulse
   always @(negedge clk) begin
      if (rst_n && done2) begin
         if (q2.size() == 0) begin
            check("n2_unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            check("n2_err_count", int'(err2), e.err);
            check("n2_first_fail_vec", int'(ffv2), e.ffv);
            check("n2_fail_valid", int'(fv2), e.fv);
            check("n2_pass", int'(pass2), e.pass);
            check("n2_done_cycle", cyc, e.done_cyc);
            check("n2_dut_in_at_done", int'(in2), 3);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done3) begin
         if (q3.size() == 0) begin
            check("n3_unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q3.pop_front();
            check("n3_err_count", int'(err3), e.err);
            check("n3_first_fail_vec", int'(ffv3), e.ffv);
            check("n3_fail_valid", int'(fv3), e.fv);
            check("n3_pass", int'(pass3), e.pass);
            check("n3_done_cycle", cyc, e.done_cyc);
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((q2.size() != 0 || q3.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", int'(q2.size() + q3.size()), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic run2(input logic [2:0] m, input int fn, input int err, input int ffv,
                       input int fv, input int ps);
      exp_t e;
      @(negedge clk);
      mode2  = m;
      fn2    = fn;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      e = '{err: err, ffv: ffv, fv: fv, pass: ps, done_cyc: cyc + 12};
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      check("n2_busy_after_start", int'(busy2), 1);
      wait_drain(100);
   endtask

   initial begin
      int s;
      int n;
      exp_t e;

      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy2), 0);
      check("rst_outputs", int'({done2, pass2, err2, ffv2, fv2, in2}), 0);
      check("rst_outputs3", int'({busy3, done3, pass3, err3, ffv3, fv3, in3}), 0);
      rst_n = 1'b1;

      run2(MODE_AND,  0, 0, 0, 0, 1);
      run2(MODE_OR,   0, 2, 1, 1, 0);
      run2(MODE_NAND, 1, 3, 0, 1, 0);
      run2(MODE_XNOR, 3, 4, 0, 1, 0);
      run2(MODE_ONE,  2, 0, 0, 0, 1);
      run2(MODE_NOR,  1, 1, 0, 1, 0);

      // N=3 XOR against an XNOR gate: every vector fails, counter saturates at 3
      @(negedge clk);
      mode3  = MODE_XOR;
      fn3    = 4;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      e = '{err: 3, ffv: 0, fv: 1, pass: 0, done_cyc: cyc + 24};
      q3.push_back(e);
      @(negedge clk);
      start3 = 1'b0;
      wait_drain(100);

      // Abort an erroring sweep with reset during vector 2
      @(negedge clk);
      mode2  = MODE_OR;
      fn2    = 0;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (in2 != 2'd2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("reach_vector2", int'(in2), 2);
      check("pre_reset_err", int'(err2), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", int'(busy2), 0);
      check("async_rst_outputs", int'({done2, pass2, err2, ffv2, fv2, in2}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run2(MODE_AND, 0, 0, 0, 0, 1);

      // Start held high: back-to-back sweeps every 14 cycles, mid-sweep mode change ignored
      @(negedge clk);
      mode2  = MODE_AND;
      fn2    = 0;
      start2 = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      for (int k = 0; k < 3; k++) begin
         e = '{err: 0, ffv: 0, fv: 0, pass: 1, done_cyc: s + 12 + 14 * k};
         q2.push_back(e);
      end
      while (cyc < s + 5) @(negedge clk);
      mode2 = MODE_OR;
      while (cyc < s + 8) @(negedge clk);
      mode2 = MODE_AND;
      while (cyc < s + 39) @(negedge clk);
      start2 = 1'b0;
      wait_drain(100);
      repeat (10) @(negedge clk);
      check("idle_after_held_start", int'(busy2), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: cycle %0d reached time limit", cyc);
      $fatal(1, "timeout");
   end

endmodule
